// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch sequencer:
// the canonical NOP, the stop word, and the sequencer state encoding.
package riscv_pkg;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;
  localparam logic [31:0] STOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/riscv_prog_ram.sv
// Program buffer: synchronous write, asynchronous read, no reset on the array
// so that its contents are simply undefined after power-up.
module riscv_prog_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Append port used by the host load handshake.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/riscv_fetch_sequencer.sv
// Fetch sequencer: buffers a host-loaded program and feeds riscv_top one
// instruction per clock (free-run or single-step), padding idle cycles with NOP.
module riscv_fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             clear,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic [AW-1:0]    pc,
  output logic [AW:0]      prog_len,
  output logic             busy,
  output logic             done
);

  localparam logic [AW:0]      FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_LEN  = (AW+1)'(1);
  localparam logic [AW:0]      ZERO_LEN = (AW+1)'(0);
  localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(RISCV_NOP);
  localparam logic [WIDTH-1:0] STOP_W   = WIDTH'(STOP_WORD);

  // The internal pointer has one extra bit so "pc == prog_len == DEPTH" is
  // distinguishable; the visible pc saturates at DEPTH-1 instead of wrapping.
  function automatic logic [AW-1:0] sat_pc(input logic [AW:0] p);
    logic [AW-1:0] r;
    if (p[AW]) begin
      r = {AW{1'b1}};
    end else begin
      r = p[AW-1:0];
    end
    return r;
  endfunction

  seq_state_e       state_r, state_s;
  logic [AW:0]      pc_r, pc_s;
  logic [AW:0]      plen_r, plen_s;
  logic [WIDTH-1:0] instr_r, instr_s;
  logic             valid_r, valid_s;
  logic [AW-1:0]    pc_out_r;
  logic             busy_r, done_r;

  logic             accept_s;
  logic [WIDTH-1:0] rdata_s;
  logic             stop_s;
  logic             last_s;
  logic             can_step_s;
  logic [AW:0]      plen_acc_s;

  assign load_ready = (state_r == SEQ_IDLE) && (plen_r < FULL_LEN);
  assign accept_s   = load_valid && load_ready;
  assign plen_acc_s = accept_s ? (plen_r + ONE_LEN) : plen_r;

  riscv_prog_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_prog_ram (
    .clk   (clk),
    .we    (accept_s),
    .waddr (plen_r[AW-1:0]),
    .wdata (load_data),
    .raddr (pc_r[AW-1:0]),
    .rdata (rdata_s)
  );

  assign stop_s     = (rdata_s == STOP_W);
  assign last_s     = (pc_r == (plen_r - ONE_LEN));
  assign can_step_s = (pc_r < plen_r);

  // Next-state, pointer and issue decode; halt_req > clear > start > step.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    plen_s  = plen_acc_s;
    instr_s = NOP_W;
    valid_s = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (halt_req) begin
          state_s = SEQ_IDLE;
        end else if (clear) begin
          plen_s = ZERO_LEN;
          pc_s   = ZERO_LEN;
        end else if (start) begin
          // a word accepted in this same cycle counts toward a non-empty buffer
          if (plen_acc_s != ZERO_LEN) begin
            state_s = SEQ_RUN;
            pc_s    = ZERO_LEN;
          end else begin
            state_s = SEQ_IDLE;
          end
        end else if (step) begin
          if (can_step_s && !stop_s) begin
            instr_s = rdata_s;
            valid_s = 1'b1;
            pc_s    = pc_r + ONE_LEN;
          end else begin
            state_s = SEQ_DONE;
          end
        end else begin
          state_s = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (halt_req) begin
          state_s = SEQ_IDLE;
        end else if (stop_s) begin
          state_s = SEQ_DONE;
        end else begin
          instr_s = rdata_s;
          valid_s = 1'b1;
          pc_s    = pc_r + ONE_LEN;
          if (last_s) begin
            state_s = SEQ_DONE;
          end else begin
            state_s = SEQ_RUN;
          end
        end
      end
      SEQ_DONE: begin
        if (halt_req) begin
          state_s = SEQ_DONE;
        end else if (clear) begin
          state_s = SEQ_IDLE;
          plen_s  = ZERO_LEN;
          pc_s    = ZERO_LEN;
        end else if (start && (plen_r != ZERO_LEN)) begin
          state_s = SEQ_RUN;
          pc_s    = ZERO_LEN;
        end else begin
          state_s = SEQ_DONE;
        end
      end
      default: begin
        state_s = SEQ_IDLE;
        pc_s    = ZERO_LEN;
        plen_s  = ZERO_LEN;
      end
    endcase
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= SEQ_IDLE;
      pc_r     <= ZERO_LEN;
      plen_r   <= ZERO_LEN;
      instr_r  <= NOP_W;
      valid_r  <= 1'b0;
      pc_out_r <= {AW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      plen_r   <= plen_s;
      instr_r  <= instr_s;
      valid_r  <= valid_s;
      pc_out_r <= sat_pc(pc_s);
      busy_r   <= (state_s == SEQ_RUN);
      done_r   <= (state_s == SEQ_DONE);
    end
  end

  assign instr_out   = instr_r;
  assign instr_valid = valid_r;
  assign pc          = pc_out_r;
  assign prog_len    = plen_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: doc/riscv_fetch_sequencer.md
# riscv_fetch_sequencer

Instruction sequencer that sits in front of `riscv_top` and drives its 32-bit instruction input (`addr`) once per cycle. A host loads a short program into an internal buffer through a valid/ready handshake, then starts it. The block issues one instruction per clock in free-run or single-step mode and pads every idle cycle with a canonical NOP. Direct instruction poking from a bench or SoC wrapper is no longer needed.

## Interface
- `WIDTH`, 32, instruction width
- `DEPTH`, 16, program buffer entries (power of 2, ≥2)
- `AW`, $clog2(DEPTH), pointer width (derived, not overridden)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  host offers `load_data`
- `load_ready`  out  1  buffer accepts a word this cycle
- `load_data`  in  WIDTH  instruction word to append
- `start`  in  1  pulse: run program from entry 0
- `step`  in  1  pulse: issue one instruction at `pc`
- `halt_req`  in  1  abort run, return to IDLE
- `clear`  in  1  empty buffer, reset `pc`
- `instr_out`  out  WIDTH  connects to `riscv_top.addr`
- `instr_valid`  out  1  `instr_out` carries a program word (not padding)
- `pc`  out  AW  index of next word to issue
- `prog_len`  out  AW+1  number of words loaded
- `busy`  out  1  state is RUN
- `done`  out  1  state is DONE

## Operation
- States:
  - IDLE: load, step, start and clear are accepted.
  - RUN: free-running issue.
  - DONE: program exhausted.
- Load:
  - `load_ready = (state==IDLE) && (prog_len < DEPTH)`.
  - On `load_valid && load_ready`, write `mem[prog_len]` and increment `prog_len`.
- IDLE→RUN on `start` when `prog_len != 0` (counting a word accepted the same cycle). `pc` is set to 0.
  - `start` with an empty buffer is ignored.
- RUN, each cycle:
  - If `mem[pc] == 0` (stop word): issue NOP and go to DONE.
  - Otherwise issue `mem[pc]` and increment `pc`.
  - When the issued word is the one at `prog_len-1`, go to DONE.
- IDLE + `step` with `pc < prog_len`:
  - Issue `mem[pc]` and increment `pc`. The state stays IDLE.
  - Step on the stop word or with `pc == prog_len` issues NOP and goes to DONE.
- `halt_req` in RUN: issue NOP that cycle and go to IDLE. `pc` keeps its value, so `step` can continue from there.
- DONE:
  - `start` → RUN from `pc=0`; the buffer is retained.
  - `clear` → IDLE.
- `clear` (IDLE or DONE): `prog_len=0`, `pc=0`, state IDLE. `clear` is ignored in RUN.
- Priority in the same cycle: `halt_req` > `clear` > `start` > `step`.
- NOP = 32'h0000_0013 (ADDI x0,x0,0). It is driven whenever no program word is issued.

## Timing
- All outputs are registered except `load_ready`, which is decoded from state and `prog_len`.
- Reset values: `instr_out`=NOP, `instr_valid`=0, `pc`=0, `prog_len`=0, `busy`=0, `done`=0, state IDLE. The buffer contents are undefined after reset.
- Latency from `start` to output: `start` sampled at edge N puts `mem[0]` on `instr_out` after edge N+1. `busy` rises after edge N.
- Free-run: words issue on consecutive cycles with no bubbles. A program of L words with no stop word occupies L cycles. `done` rises after the edge that issued word L-1.
- `halt_req` at edge M: `instr_out`=NOP and `instr_valid`=0 after edge M. `busy` falls after edge M.
- A full buffer (`prog_len==DEPTH`) drops `load_ready` and holds it low until `clear`. `pc` never wraps; the last index is DEPTH-1.
- Reset asserted mid-run forces all outputs to their reset values immediately (asynchronous) and discards the program.

## Structure
- Shared package `riscv_pkg`:
  - `RISCV_NOP` constant.
  - Sequencer state encoding (IDLE/RUN/DONE).
  - `STOP_WORD` constant (0).
- Sub-module `riscv_prog_ram`: DEPTH×WIDTH, synchronous write, asynchronous read, no reset on the array.
- The FSM, pointers and output registers stay in the top level.

## Test plan
- Reset, then load 12 words (ADDI 0x00A08093 … SLL 0x00411633) and pulse `start`: `instr_out` shows the 12 words on 12 consecutive cycles with `instr_valid`=1. Then `done`=1 and `instr_out`=0x00000013.
- Load 0x00A08093, 0x00000000, 0x00A10113 and start: one valid word issues, then NOP and `done`. Word 2 is never issued.
- Load 16 words: `load_ready`=0 after the 16th. A 17th `load_valid` is not accepted and `prog_len` stays 16.
- Run 12 words and assert `halt_req` on the 4th issue cycle: the next output is NOP with `busy`=0 and `pc`=4. Three `step` pulses then issue words 4, 5, 6.
- `start` with `prog_len`=0: the state stays IDLE and `instr_valid` stays 0. `start` and `halt_req` in the same cycle while in RUN: halt wins.
- Drop `rst` to 0 mid-run (asynchronously, between edges): outputs go to their reset values immediately, and `prog_len`=0 after release.
